// File: rtl/vga_rx_monitor.sv
// Receive-side 640x480 VGA monitor: locks to the incoming raster, recovers active-pixel
// coordinates/colour, flags timing violations and counts lit pixels per locked frame.
module vga_rx_monitor #(
  parameter int unsigned HPIXELS = 800,
  parameter int unsigned VLINES  = 521,
  parameter int unsigned HPULSE  = 96,
  parameter int unsigned VPULSE  = 2,
  parameter int unsigned HBP     = 144,
  parameter int unsigned HFP     = 784,
  parameter int unsigned VBP     = 31,
  parameter int unsigned VFP     = 511
) (
  input  logic        dclk,
  input  logic        clr,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [2:0]  red,
  input  logic [2:0]  green,
  input  logic [1:0]  blue,
  output logic        locked,
  output logic        px_valid,
  output logic [9:0]  px_x,
  output logic [9:0]  px_y,
  output logic [7:0]  px_rgb,
  output logic        frame_start,
  output logic        timing_err,
  output logic [7:0]  err_cnt,
  output logic [18:0] lit_cnt
);

  localparam logic [9:0] HLast      = 10'(HPIXELS - 1);
  localparam logic [9:0] VLast      = 10'(VLINES - 1);
  localparam logic [9:0] HPulseLast = 10'(HPULSE - 1);
  localparam logic [9:0] VPulseLast = 10'(VPULSE - 1);
  localparam logic [9:0] HStart     = 10'(HBP);
  localparam logic [9:0] HStop      = 10'(HFP);
  localparam logic [9:0] VStart     = 10'(VBP);
  localparam logic [9:0] VStop      = 10'(VFP);

  typedef enum logic [1:0] {StSearch, StCheck, StLocked} state_e;

  state_e      state;
  logic        hs1, vs1, hs_p, vs_p;
  logic [7:0]  rgb1, rgb2;
  logic [9:0]  h, v;
  logic        origin_q, viol_q;
  logic [18:0] acc;

  // Stage 1: input capture plus the previous sample for edge detection.
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      hs1  <= 1'b1;
      vs1  <= 1'b1;
      hs_p <= 1'b1;
      vs_p <= 1'b1;
      rgb1 <= '0;
    end else begin
      hs1  <= hsync;
      vs1  <= vsync;
      hs_p <= hs1;
      vs_p <= vs1;
      rgb1 <= {red, green, blue};
    end
  end

  logic hfall, hrise, vfall, vrise, origin;
  logic bad_hspace, bad_hwidth, bad_vedge, bad_vwidth, bad_vspace, viol;

  // h and v still index the previous sample here, so expected values are one less.
  assign hfall      = hs_p & ~hs1;
  assign hrise      = ~hs_p & hs1;
  assign vfall      = vs_p & ~vs1;
  assign vrise      = ~vs_p & vs1;
  assign origin     = hfall & vfall;
  assign bad_hspace = hfall ? (h != HLast) : (h == HLast);
  assign bad_hwidth = hrise ? (h != HPulseLast) : (~hs1 & ~hfall & (h == HPulseLast));
  assign bad_vedge  = (vfall | vrise) & ~hfall;
  assign bad_vwidth = hfall & ~origin & (vrise ? (v != VPulseLast) : (~vs1 & (v == VPulseLast)));
  assign bad_vspace = hfall & (origin ? (v != VLast) : (v == VLast));
  assign viol       = bad_hspace | bad_hwidth | bad_vedge | bad_vwidth | bad_vspace;

  // Stage 2: raster position of the sample captured one cycle earlier.
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      h        <= '0;
      v        <= '0;
      rgb2     <= '0;
      origin_q <= 1'b0;
      viol_q   <= 1'b0;
    end else begin
      h <= hfall ? 10'd0 : h + 10'd1;
      if (origin) begin
        v <= '0;
      end else if (hfall) begin
        v <= v + 10'd1;
      end
      rgb2     <= rgb1;
      origin_q <= origin;
      viol_q   <= viol;
    end
  end

  logic stay_lock, in_active;

  assign stay_lock = ~viol_q & ((state == StLocked) | ((state == StCheck) & origin_q));
  assign in_active = (h >= HStart) & (h < HStop) & (v >= VStart) & (v < VStop);

  // Stage 3: lock FSM and all registered outputs.
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      state       <= StSearch;
      locked      <= 1'b0;
      px_valid    <= 1'b0;
      px_x        <= '0;
      px_y        <= '0;
      px_rgb      <= '0;
      frame_start <= 1'b0;
      timing_err  <= 1'b0;
      err_cnt     <= '0;
      lit_cnt     <= '0;
      acc         <= '0;
    end else begin
      frame_start <= origin_q & stay_lock;
      timing_err  <= 1'b0;
      locked      <= stay_lock;
      px_valid    <= stay_lock & in_active;
      if (stay_lock & in_active) begin
        px_x   <= h - HStart;
        px_y   <= v - VStart;
        px_rgb <= rgb2;
      end
      if (px_valid && (px_rgb != 8'd0)) begin
        acc <= acc + 19'd1;
      end
      case (state)
        StSearch: begin
          if (origin_q) state <= StCheck;
        end
        StCheck: begin
          if (viol_q) begin
            state <= StSearch;
          end else if (origin_q) begin
            state <= StLocked;
            acc   <= '0;
          end
        end
        StLocked: begin
          if (viol_q) begin
            state      <= StSearch;
            timing_err <= 1'b1;
            acc        <= '0;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          end else if (origin_q) begin
            lit_cnt <= acc;
            acc     <= '0;
          end
        end
        default: state <= StSearch;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Bench for vga_rx_monitor on a shrunken raster: a frame generator pushes expected pixels to a
// scoreboard, a monitor pops them as px_valid appears; lock/error/lit behaviour checked per frame.
module tb_vga_rx_monitor;

  localparam int HP  = 12;
  localparam int VL  = 7;
  localparam int HPW = 2;
  localparam int VPW = 2;
  localparam int HB  = 3;
  localparam int HF  = 11;
  localparam int VB  = 3;
  localparam int VF  = 6;

  logic        dclk = 1'b0;
  logic        clr;
  logic        hsync, vsync;
  logic [2:0]  red, green;
  logic [1:0]  blue;
  logic        locked, px_valid, frame_start, timing_err;
  logic [9:0]  px_x, px_y;
  logic [7:0]  px_rgb, err_cnt;
  logic [18:0] lit_cnt;

  vga_rx_monitor #(
    .HPIXELS(HP), .VLINES(VL), .HPULSE(HPW), .VPULSE(VPW),
    .HBP(HB), .HFP(HF), .VBP(VB), .VFP(VF)
  ) dut (
    .dclk        (dclk),
    .clr         (clr),
    .hsync       (hsync),
    .vsync       (vsync),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .locked      (locked),
    .px_valid    (px_valid),
    .px_x        (px_x),
    .px_y        (px_y),
    .px_rgb      (px_rgb),
    .frame_start (frame_start),
    .timing_err  (timing_err),
    .err_cnt     (err_cnt),
    .lit_cnt     (lit_cnt)
  );

  always #5 dclk = ~dclk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          te_cnt   = 0;
  int          exp_err  = 0;
  bit          exp_locked = 1'b0;
  logic [27:0] sb_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat_rgb(input int pat, input int x, input int y);
    if (pat == 1) return (x >= 3 && x < 5 && y >= 1 && y < 3) ? 8'hFC : 8'h00;
    if (pat == 2) return 8'(x * 29 + y * 7 + 1);
    return 8'h00;
  endfunction

  function automatic logic [63:0] all_outs();
    return 64'({locked, px_valid, px_x, px_y, px_rgb, frame_start, timing_err, err_cnt, lit_cnt});
  endfunction

  // kind: 0 clean, 1 hsync pulse one short on bad_line, 2 bad_line one cycle short,
  // 3 clr pulse at the start of bad_line.
  task automatic drive_frame(input bit lock_after, input int exp_lit, input int kind,
                             input int bad_line, input int pat);
    bit was;
    int len, hpw;
    logic [7:0] rgb;
    for (int v = 0; v < VL; v++) begin
      len = (kind == 2 && v == bad_line) ? HP - 1 : HP;
      hpw = (kind == 1 && v == bad_line) ? HPW - 1 : HPW;
      for (int h = 0; h < len; h++) begin
        @(negedge dclk);
        if (v == 0 && h == 2) begin
          check_eq("lock_pre", 64'(locked), 64'(exp_locked));
          check_eq("fs_pre", 64'(frame_start), 64'd0);
        end
        if (v == 0 && h == 3) begin
          check_eq("lock", 64'(locked), 64'(lock_after));
          check_eq("frame_start", 64'(frame_start), 64'(lock_after));
          check_eq("lit_cnt", 64'(lit_cnt), 64'(exp_lit));
          check_eq("err_cnt", 64'(err_cnt), 64'(exp_err));
          exp_locked = lock_after;
        end
        if (kind == 1 && v == bad_line) begin
          if (h == 1) begin
            was = exp_locked;
            exp_locked = 1'b0;
          end
          if (h == 4) begin
            check_eq("terr", 64'(timing_err), 64'(was));
            check_eq("lock_drop", 64'(locked), 64'd0);
            if (was && exp_err < 255) exp_err++;
            check_eq("err_cnt_v", 64'(err_cnt), 64'(exp_err));
          end
          if (h == 5) check_eq("terr_width", 64'(timing_err), 64'd0);
        end
        if (kind == 3 && v == bad_line) begin
          if (h == 0) begin
            clr = 1'b1;
            #1;
            check_eq("clr_outs", all_outs(), 64'd0);
            sb_q.delete();
            exp_err = 0;
            exp_locked = 1'b0;
          end
          if (h == 2) clr = 1'b0;
        end
        rgb = 8'h00;
        if (h >= HB && h < HF && v >= VB && v < VF) begin
          rgb = pat_rgb(pat, h - HB, v - VB);
          if (exp_locked) sb_q.push_back({10'(h - HB), 10'(v - VB), rgb});
        end
        hsync = !(h < hpw);
        vsync = !(v < VPW);
        {red, green, blue} = rgb;
      end
    end
  endtask

  // Output monitor, sampled well after the active edge.
  initial begin
    logic [27:0] e;
    forever begin
      @(posedge dclk);
      #2;
      if (px_valid) begin
        check_eq("px_pending", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check_eq("px", 64'({px_x, px_y, px_rgb}), 64'(e));
        end
      end
      if (timing_err) te_cnt++;
    end
  end

  initial begin
    clr = 1'b1;
    hsync = 1'b1;
    vsync = 1'b1;
    {red, green, blue} = 8'h00;
    repeat (3) @(negedge dclk);
    check_eq("reset_outs", all_outs(), 64'd0);
    clr = 1'b0;

    // Lock acquisition, blank and sprite frames.
    drive_frame(1'b0, 0, 0, 0, 0);
    drive_frame(1'b1, 0, 0, 0, 0);
    drive_frame(1'b1, 0, 0, 0, 1);
    // Locked hsync violation, then a short line while checking.
    drive_frame(1'b1, 4, 1, 1, 0);
    drive_frame(1'b0, 4, 2, 4, 0);
    drive_frame(1'b0, 4, 0, 0, 0);
    check_eq("terr_total_a", 64'(te_cnt), 64'd1);
    drive_frame(1'b1, 4, 0, 0, 2);
    // Mid-frame clear and relock.
    drive_frame(1'b1, 24, 3, 4, 0);
    drive_frame(1'b0, 0, 0, 0, 0);
    drive_frame(1'b1, 0, 0, 0, 2);
    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin
      drive_frame(1'b1, 24, 1, 1, 0);
      drive_frame(1'b0, 24, 0, 0, 0);
    end
    repeat (4) @(negedge dclk);
    check_eq("err_sat", 64'(err_cnt), 64'd255);
    check_eq("terr_total", 64'(te_cnt), 64'd301);
    check_eq("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
